// File: rtl/pci_mon_pkg.sv
// Shared definitions for the passive PCI bus monitor: state encodings
// and the PCI command codes the debug logic decodes.
package pci_mon_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DECODE     = 3'd1;
  localparam logic [2:0] ST_WAIT       = 3'd2;
  localparam logic [2:0] ST_DATA       = 3'd3;
  localparam logic [2:0] ST_FINAL      = 3'd4;
  localparam logic [2:0] ST_DISCONNECT = 3'd5;
  localparam logic [2:0] ST_ABORT      = 3'd6;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    DECODE     = ST_DECODE,
    WAIT       = ST_WAIT,
    DATA       = ST_DATA,
    FINAL      = ST_FINAL,
    DISCONNECT = ST_DISCONNECT,
    ABORT      = ST_ABORT
  } mon_state_e;

  localparam logic [3:0] IO_READ   = 4'h2;
  localparam logic [3:0] IO_WRITE  = 4'h3;
  localparam logic [3:0] MEM_READ  = 4'h6;
  localparam logic [3:0] MEM_WRITE = 4'h7;

endpackage

// File: rtl/pci_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module pci_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         sat_o
);

  logic [W-1:0] count_q;

  assign sat_o   = &count_q;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) count_q <= '0;
    else if (inc_i && !sat_o) count_q <= count_q + 1'b1;
  end

endmodule

// File: rtl/pci_bus_monitor.sv
// Passive PCI bus-phase tracker: latches address/command, counts data
// phases and flags master abort, target abort and disconnect.
//
// state      | meaning
// IDLE       | bus idle or not yet synchronised to a transaction boundary
// DECODE     | address phase seen, waiting for DEVSEL#
// WAIT       | data phase pending, IRDY# or TRDY# not yet asserted
// DATA       | at least one data phase done, more to follow
// FINAL      | last data phase done, waiting for IRDY# release
// DISCONNECT | target signalled STOP#, waiting for bus release
// ABORT      | master or target abort, waiting for bus release
module pci_bus_monitor
  import pci_mon_pkg::*;
#(
  parameter int AD_W           = 32,
  parameter int CNT_W          = 8,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             irdy,
  input  logic             trdy,
  input  logic             devsel,
  input  logic             stop,
  input  logic [AD_W-1:0]  ad,
  input  logic [3:0]       cbe,
  output logic [2:0]       state,
  output logic [AD_W-1:0]  addr,
  output logic [3:0]       cmd,
  output logic             is_write,
  output logic             busy,
  output logic [CNT_W-1:0] phase_count,
  output logic             xfer,
  output logic             done,
  output logic             master_abort,
  output logic             target_abort,
  output logic             disconnect
);

  localparam logic [3:0] DEC_LAST = 4'(DEVSEL_TIMEOUT - 1);

  mon_state_e      state_q, state_d;
  logic [AD_W-1:0] addr_q, addr_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            synced_q, synced_d;
  logic            xfer_q, xfer_d, done_q, done_d;
  logic            mabort_q, mabort_d, tabort_q, tabort_d, disc_q, disc_d;
  logic            capture, dec_inc, pc_inc, pc_sat, dec_sat, dec_hit;
  logic [3:0]      dec_cnt;

  pci_sat_counter #(.W(CNT_W)) u_phase_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (capture),
    .inc_i   (pc_inc),
    .count_o (phase_count),
    .sat_o   (pc_sat)
  );

  pci_sat_counter #(.W(4)) u_decode_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (capture),
    .inc_i   (dec_inc),
    .count_o (dec_cnt),
    .sat_o   (dec_sat)
  );

  assign dec_hit = dec_sat | (dec_cnt == DEC_LAST);
  assign pc_inc  = xfer_d & ~pc_sat;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    xfer_d   = 1'b0;
    done_d   = 1'b0;
    mabort_d = 1'b0;
    tabort_d = 1'b0;
    disc_d   = 1'b0;
    dec_inc  = 1'b0;
    capture  = 1'b0;
    // An idle bus (FRAME# and IRDY# both released) marks a safe boundary.
    synced_d = synced_q | (frame & irdy);
    case (state_q)
      IDLE: capture = ~frame & synced_q;
      DECODE, WAIT, DATA: begin
        if (state_q == DECODE && devsel) begin
          dec_inc = 1'b1;
          if (dec_hit) begin
            state_d  = ABORT;
            mabort_d = 1'b1;
          end
        end else if (devsel && !stop) begin
          state_d  = ABORT;
          tabort_d = 1'b1;
        end else if (!stop) begin
          state_d = DISCONNECT;
          disc_d  = 1'b1;
          xfer_d  = ~irdy & ~trdy;
        end else if (!irdy && !trdy) begin
          xfer_d  = 1'b1;
          state_d = frame ? FINAL : DATA;
        end else begin
          state_d = WAIT;
        end
      end
      FINAL: begin
        if (irdy) begin
          done_d = 1'b1;
          if (frame) state_d = IDLE;
          else       capture = 1'b1;
        end
      end
      DISCONNECT: begin
        if (frame && irdy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ABORT: if (frame && irdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (capture) begin
      state_d = DECODE;
      addr_d  = ad;
      cmd_d   = cbe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cmd_q    <= '0;
      synced_q <= 1'b0;
      xfer_q   <= 1'b0;
      done_q   <= 1'b0;
      mabort_q <= 1'b0;
      tabort_q <= 1'b0;
      disc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      synced_q <= synced_d;
      xfer_q   <= xfer_d;
      done_q   <= done_d;
      mabort_q <= mabort_d;
      tabort_q <= tabort_d;
      disc_q   <= disc_d;
    end
  end

  assign state        = state_q;
  assign addr         = addr_q;
  assign cmd          = cmd_q;
  assign is_write     = cmd_q[0];
  assign busy         = (state_q != IDLE);
  assign xfer         = xfer_q;
  assign done         = done_q;
  assign master_abort = mabort_q;
  assign target_abort = tabort_q;
  assign disconnect   = disc_q;

endmodule

// File: doc/pci_bus_monitor.md
# pci_bus_monitor

Passive, parametrised PCI bus-phase tracker and the successor to the single-purpose read state machine. It samples the active-low shared control lines on every rising clock edge and tracks both read and write transactions. It captures the address and command, counts completed data phases, and reports master abort, target abort and target disconnect. It sits beside the PCI pins, feeds the debug/statistics logic and never drives the bus.

## Interface
Parameters:
- AD_W, 32, width of the ad bus and the captured address.
- CNT_W, 8, width of the phase_count output; the counter saturates at all-ones.
- DEVSEL_TIMEOUT, 5, number of DECODE samples without devsel before a master abort; legal range 2..15.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  bus clock; all sampling on the rising edge.
- rst  in  1  synchronous, active-high reset.
- frame  in  1  active-low FRAME#.
- irdy  in  1  active-low IRDY#.
- trdy  in  1  active-low TRDY#.
- devsel  in  1  active-low DEVSEL#.
- stop  in  1  active-low STOP#.
- ad  in  AD_W  address/data bus.
- cbe  in  4  command/byte-enable bus.
- state  out  3  current state encoding.
- addr  out  AD_W  address latched at the address phase.
- cmd  out  4  command latched at the address phase.
- is_write  out  1  equals cmd[0].
- busy  out  1  high whenever state is not IDLE.
- phase_count  out  CNT_W  completed data phases in the current transaction.
- xfer  out  1  one-cycle pulse: a data phase completed at the previous edge.
- done  out  1  one-cycle pulse: a transaction ended normally or by disconnect.
- master_abort  out  1  one-cycle pulse.
- target_abort  out  1  one-cycle pulse.
- disconnect  out  1  one-cycle pulse: STOP# was sampled during a data phase.

## Operation
- State encodings: IDLE=0, DECODE=1, WAIT=2, DATA=3, FINAL=4, DISCONNECT=5, ABORT=6.
- synced flag:
  - Cleared by rst.
  - Set when frame=1 and irdy=1 are sampled together.
  - IDLE leaves only while synced=1, so the block never joins a transaction mid-flight.
- IDLE:
  - Condition: frame=0 and synced=1.
  - Action: go to DECODE; latch addr←ad and cmd←cbe; clear phase_count and the decode counter.
- DECODE with devsel=1:
  - Increment the decode counter.
  - On the DEVSEL_TIMEOUT-th such sample, go to ABORT and pulse master_abort.
- DECODE with devsel=0: apply the data-phase evaluation E.
- WAIT and DATA: apply E.
- Data-phase evaluation E, first matching rule wins:
  1. devsel=1 and stop=0: go to ABORT and pulse target_abort.
  2. stop=0: go to DISCONNECT and pulse disconnect. If irdy=0 and trdy=0 in the same sample, also count the phase and pulse xfer.
  3. irdy=0 and trdy=0: pulse xfer and increment phase_count. Go to FINAL if frame=1, otherwise go to DATA.
  4. Otherwise: go to WAIT.
- FINAL:
  - irdy=1 and frame=1: go to IDLE and pulse done.
  - irdy=1 and frame=0 (fast back-to-back): pulse done and go directly to DECODE, applying the IDLE capture actions.
  - irdy=0: stay in FINAL.
- DISCONNECT: on frame=1 and irdy=1, go to IDLE and pulse done.
- ABORT: on frame=1 and irdy=1, go to IDLE. No done pulse.
- Undefined encodings 7 and above go to IDLE on the next edge.
- phase_count is a CNT_W-bit saturating counter; it holds at 2^CNT_W−1.

## Timing
- All outputs are registered and update on the edge that sampled the causing inputs, so latency is one clock from input sampling to output.
- Every pulse is exactly one cycle wide. Pulses do not stretch across consecutive events; back-to-back data phases give xfer high on consecutive cycles.
- addr and cmd hold their values until the next address capture.
- Reset values: state=IDLE, synced=0, addr=0, cmd=0, is_write=0, busy=0, phase_count=0, all pulses 0.
- rst asserted mid-transaction: the block returns to IDLE on the next edge with no done or abort pulse, then waits for synced before tracking again.
- Master abort timing: with DEVSEL_TIMEOUT=5, devsel held high, and frame first sampled low at edge N, master_abort is high during the cycle after edge N+5.

## Structure
- Shared package pci_mon_pkg holds:
  - the 3-bit state localparams;
  - the PCI command constants (MEM_READ=4'h6, MEM_WRITE=4'h7, IO_READ=4'h2, IO_WRITE=4'h3).
- Sub-module pci_sat_counter: parametrised width, with clear, increment and a saturation flag.
  - One instance implements phase_count.
  - A second instance, 4 bits wide, implements the decode counter.

## Test plan
- Read burst:
  - Stimulus: cbe=6, devsel low at the second sample, 4 phases with irdy and trdy low, frame high on the 4th phase.
  - Required: phase_count=4, xfer four times, FINAL then IDLE, done once, is_write=0.
- Write with wait states:
  - Stimulus: cbe=7, trdy high for 2 cycles between phases.
  - Required: state shows WAIT for those cycles, no xfer during them, is_write=1.
- Master abort:
  - Stimulus: devsel never asserted, DEVSEL_TIMEOUT=5.
  - Required: master_abort on the 5th DECODE sample, ABORT, IDLE once frame and irdy are high, no done.
- Disconnect:
  - Stimulus: stop and trdy low on the 2nd phase.
  - Required: phase_count=2, disconnect pulse, done after frame and irdy are high.
- Fast back-to-back:
  - Stimulus: in FINAL, irdy=1 and frame=0 with ad=32'h1000.
  - Required: done pulse, DECODE, addr=32'h1000, phase_count=0.
- Reset mid-transaction and saturation:
  - Stimulus: rst during DATA with frame still low; separately, 300 phases with CNT_W=8.
  - Required: for rst, IDLE and no tracking until frame and irdy are both high; for the long burst, phase_count holds at 255.
